// File: rtl/cordic_slice_host_if.sv
// cordic_slice_host_if: host word handshake, 2-bit slice link and result bus.
// s_*: parallel X/Y/A input words with valid/ready and the invert-sign sideband.
// lnk_*: frame pulse, outgoing slices and sideband, returned slices, frame-complete strobe.
// m_*: reassembled result words with a one-cycle valid. err: sticky link protocol error.
interface cordic_slice_host_if;
  logic        s_valid, s_ready, s_is;
  logic [11:0] s_x, s_y, s_a;
  logic        lnk_rdy, lnk_is, lnk_vld;
  logic [1:0]  lnk_x, lnk_y, lnk_a, lnk_xr, lnk_yr, lnk_ar;
  logic        m_valid, err;
  logic [11:0] m_x, m_y, m_a;
  modport slave (
    input  s_valid, s_x, s_y, s_a, s_is, lnk_vld, lnk_xr, lnk_yr, lnk_ar,
    output s_ready, lnk_rdy, lnk_x, lnk_y, lnk_a, lnk_is, m_valid, m_x, m_y, m_a, err
  );
  modport master (
    output s_valid, s_x, s_y, s_a, s_is, lnk_vld, lnk_xr, lnk_yr, lnk_ar,
    input  s_ready, lnk_rdy, lnk_x, lnk_y, lnk_a, lnk_is, m_valid, m_x, m_y, m_a, err
  );
endinterface

// File: rtl/cordic_slice_host.sv
// cordic_slice_host: serializes 12-bit X/Y/A words into six 2-bit slices per frame and
// reassembles the slices the stage returns for the previous frame.
// clk/rst: clock and asynchronous active-high reset. bus: cordic_slice_host_if slave view.
module cordic_slice_host (
  input  logic                  clk,
  input  logic                  rst,
  cordic_slice_host_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, SHIFT, CHECK} state_t;
  state_t      st, st_n;
  logic [2:0]  cnt;
  logic [11:0] sx, sy, sa;
  logic [9:0]  rx, ry, ra;
  logic        is_n, pend, pub, chk, last, dec, real_f, go;
  always_comb begin
    last   = st == SHIFT && cnt == 3'd5;
    dec    = st == IDLE || last;
    real_f = dec && bus.s_valid;
    go     = real_f || (dec && pend);
    st_n   = go ? LAUNCH : st == LAUNCH ? SHIFT : last ? CHECK : st == SHIFT ? SHIFT : IDLE;
  end
  assign bus.s_ready = dec;
  assign bus.lnk_rdy = st == LAUNCH;
  assign bus.lnk_x   = st == SHIFT ? sx[1:0] : 2'b0;
  assign bus.lnk_y   = st == SHIFT ? sy[1:0] : 2'b0;
  assign bus.lnk_a   = st == SHIFT ? sa[1:0] : 2'b0;
  // pub remembers whether the frame now in flight was launched with a result pending,
  // i.e. whether the slices it brings back belong to a real word.
  // chk marks the cycle after the last slice, where the stage must strobe lnk_vld.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st          <= IDLE;
      cnt         <= 3'd0;
      {sx, sy, sa} <= 36'd0;
      {rx, ry, ra} <= 30'd0;
      is_n        <= 1'b0;
      pend        <= 1'b0;
      pub         <= 1'b0;
      chk         <= 1'b0;
      bus.lnk_is  <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_x     <= 12'd0;
      bus.m_y     <= 12'd0;
      bus.m_a     <= 12'd0;
      bus.err     <= 1'b0;
    end else begin
      st          <= st_n;
      cnt         <= st == SHIFT ? cnt + 3'd1 : 3'd0;
      chk         <= last;
      {sx, sy, sa} <= go ? (real_f ? {bus.s_x, bus.s_y, bus.s_a} : 36'd0)
                    : st == SHIFT ? {sx >> 2, sy >> 2, sa >> 2} : {sx, sy, sa};
      is_n        <= go ? real_f && bus.s_is : is_n;
      pend        <= go ? real_f : pend;
      pub         <= go ? pend : pub;
      // the sideband follows its frame only once the launch pulse is out, so it
      // stays valid through the check cycle even when the next frame overlaps
      bus.lnk_is  <= st == LAUNCH ? is_n : bus.lnk_is;
      {rx, ry, ra} <= st == SHIFT ? {bus.lnk_xr, rx[9:2], bus.lnk_yr, ry[9:2], bus.lnk_ar, ra[9:2]}
                    : {rx, ry, ra};
      bus.m_valid <= last && pub;
      bus.m_x     <= last && pub ? {bus.lnk_xr, rx} : bus.m_x;
      bus.m_y     <= last && pub ? {bus.lnk_yr, ry} : bus.m_y;
      bus.m_a     <= last && pub ? {bus.lnk_ar, ra} : bus.m_a;
      bus.err     <= bus.err || (chk != bus.lnk_vld);
    end
endmodule

// File: tb/tb_cordic_slice_host.sv
// tb_cordic_slice_host: directed frames against a stage model that returns the previous frame's word.
module tb_cordic_slice_host;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  cordic_slice_host_if ifc();
  cordic_slice_host dut (.clk(clk), .rst(rst), .bus(ifc));
  int cyc = 0, checks = 0, fails = 0, last = -100;
  always @(posedge clk) cyc++;
  logic [11:0] cx = 0, cy = 0, ca = 0, px = 0, py = 0, pa = 0;
  logic [11:0] qx[$], qy[$], qa[$];
  int qc[$], rdy_q[$];
  bit omit = 0, spur = 0, vm = 0;
  assign ifc.lnk_vld = vm | spur;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [47:0] outs();
    return {1'b0, ifc.lnk_rdy, ifc.lnk_x, ifc.lnk_y, ifc.lnk_a, ifc.lnk_is, ifc.m_valid, ifc.err,
            ifc.m_x, ifc.m_y, ifc.m_a};
  endfunction

  // stage model: captures the outgoing frame, returns the previous one, strobes lnk_vld at T+7
  always @(negedge clk) begin : stage
    int idx;
    if (rst) begin
      last = -100;
      vm = 0;
      ifc.lnk_xr = 0; ifc.lnk_yr = 0; ifc.lnk_ar = 0;
    end else begin
      idx = cyc - last - 1;
      vm = 0;
      ifc.lnk_xr = 0; ifc.lnk_yr = 0; ifc.lnk_ar = 0;
      if (idx >= 0 && idx <= 5) begin
        cx[2*idx +: 2] = ifc.lnk_x; cy[2*idx +: 2] = ifc.lnk_y; ca[2*idx +: 2] = ifc.lnk_a;
        ifc.lnk_xr = px[2*idx +: 2]; ifc.lnk_yr = py[2*idx +: 2]; ifc.lnk_ar = pa[2*idx +: 2];
      end else if (idx == 6) begin
        vm = !omit;
        px = cx; py = cy; pa = ca;
      end
      if (ifc.lnk_rdy) last = cyc;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (ifc.lnk_rdy) rdy_q.push_back(cyc);
    if (ifc.m_valid) begin
      if (qx.size() == 0) check("m_valid_unexpected", 48'd1, 48'd0);
      else begin
        check("m_word", {12'd0, ifc.m_x, ifc.m_y, ifc.m_a}, {12'd0, qx.pop_front(), qy.pop_front(), qa.pop_front()});
        check("m_cycle", 48'(cyc), 48'(qc.pop_front()));
      end
    end
  end

  task automatic send(input logic [11:0] x, y, a, input logic is, input bit push, output int acc);
    int n = 0;
    ifc.s_valid = 1; ifc.s_x = x; ifc.s_y = y; ifc.s_a = a; ifc.s_is = is;
    while (!ifc.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!ifc.s_ready) check("send_timeout", 48'd0, 48'd1);
    else if (push) begin
      qx.push_back(x); qy.push_back(y); qa.push_back(a); qc.push_back(cyc + 15);
    end
    @(negedge clk);
    ifc.s_valid = 0; ifc.s_x = 0; ifc.s_y = 0; ifc.s_a = 0; ifc.s_is = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t, t0;
    logic [1:0] xs[9];
    logic [11:0] wx[4], wy[4], wa[4];
    xs = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    wx = '{12'h111, 12'hFFF, 12'h800, 12'h5A5};
    wy = '{12'h222, 12'h001, 12'h7FF, 12'hA5A};
    wa = '{12'h333, 12'hC00, 12'h0F0, 12'h3C3};
    ifc.s_valid = 0; ifc.s_x = 0; ifc.s_y = 0; ifc.s_a = 0; ifc.s_is = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 48'd0);
    rst = 0;
    #1 check("s_ready_after_reset", 48'(ifc.s_ready), 48'd1);
    @(negedge clk);
    // single frame: slice order and auto-flush
    send(12'h5A3, 12'h00F, 12'h3C1, 1'b0, 1'b1, t);
    for (int k = 1; k <= 8; k++) begin
      check("single_link", 48'({k == 1 || k == 8, xs[k]}), 48'({ifc.lnk_rdy, ifc.lnk_x}));
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    // loopback word whose returned slices are 0,3,2,3,2,2
    send(12'hABC, 12'h123, 12'h456, 1'b0, 1'b1, t);
    repeat (22) @(negedge clk);
    // continuous stream of four words
    rdy_q.delete();
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      send(wx[i], wy[i], wa[i], i[0], 1'b1, t);
      if (i == 0) t0 = t;
    end
    repeat (40) @(negedge clk);
    check("stream_rdy_count", 48'(rdy_q.size()), 48'd5);
    for (int i = 0; i < 5; i++)
      if (i < rdy_q.size()) check("stream_rdy_cycle", 48'(rdy_q[i]), 48'(t0 + 1 + 7 * i));
    // extreme words with invert-sign set
    send(12'h800, 12'h7FF, 12'hA5A, 1'b1, 1'b1, t);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("sign_lnk_is", 48'(ifc.lnk_is), 48'(k < 8));
    end
    repeat (20) @(negedge clk);
    check("err_clean", 48'(ifc.err), 48'd0);
    // stage omits lnk_vld at T+7
    omit = 1;
    send(12'h246, 12'h9BD, 12'h013, 1'b0, 1'b1, t);
    repeat (6) @(negedge clk);
    check("err_before_check", 48'(ifc.err), 48'd0);
    @(negedge clk);
    check("err_at_check", 48'(ifc.err), 48'd0);
    @(negedge clk);
    omit = 0;
    check("err_after_missing", 48'(ifc.err), 48'd1);
    repeat (20) @(negedge clk);
    check("err_sticky", 48'(ifc.err), 48'd1);
    rst = 1;
    @(negedge clk);
    #2 rst = 0;
    check("err_cleared_by_reset", 48'(ifc.err), 48'd0);
    @(negedge clk);
    // spurious strobe in IDLE
    spur = 1;
    @(negedge clk);
    spur = 0;
    check("err_spurious_vld", 48'(ifc.err), 48'd1);
    repeat (3) @(negedge clk);
    // reset in the middle of a frame
    send(12'h777, 12'h888, 12'h999, 1'b1, 1'b0, t);
    repeat (3) @(negedge clk);
    check("midframe_busy", 48'(ifc.lnk_x), 48'd3);
    rst = 1;
    #1 check("midframe_reset_outputs", outs(), 48'd0);
    @(negedge clk);
    #2 rst = 0;
    #1 check("midframe_s_ready", 48'(ifc.s_ready), 48'd1);
    rdy_q.delete();
    repeat (20) @(negedge clk);
    check("no_flush_after_reset", 48'(rdy_q.size()), 48'd0);
    check("queue_drained", 48'(qx.size()), 48'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
